intra16_mb_scheduler: RTL and testbench

- Frame-level sequencer for the 16x16 luma intra mode picker.
- Walks macroblocks in raster order and drives the picker's x/y, start and clear.
- Per MB: waits for the source/neighbour buffer, launches the picker, captures its done outputs into a one-entry result slot, and presents them downstream on a valid/ready handshake.
- Accumulates the frame total score.

---
 rtl/intra16_mb_scheduler_pkg.sv | 31 +++
 rtl/intra16_mb_raster_cnt.sv | 68 ++++++
 rtl/intra16_mb_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_intra16_mb_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra16_mb_scheduler_pkg.sv
// intra16_mb_scheduler_pkg: shared types for the 16x16 intra macroblock scheduler.
// Holds the one-hot FSM encoding, default coordinate width and result record layout.
package intra16_mb_scheduler_pkg;

    localparam int MBW_W_DEF = 10;
    localparam int MODE_W    = 2;
    localparam int NZ_W      = 32;
    localparam int SCORE_W   = 64;

    typedef enum logic [6:0] {
        ST_IDLE   = 7'b000_0001,
        ST_CLEAR  = 7'b000_0010,
        ST_FETCH  = 7'b000_0100,
        ST_LAUNCH = 7'b000_1000,
        ST_WAIT   = 7'b001_0000,
        ST_DRAIN  = 7'b010_0000,
        ST_DONE   = 7'b100_0000
    } sched_state_e;

    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [NZ_W-1:0]    nz;
        logic [SCORE_W-1:0] score;
    } mb_result_t;

    // The result slot can take a new capture if it is empty or is being drained this cycle.
    function automatic logic slot_free(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/intra16_mb_raster_cnt.sv
// intra16_mb_raster_cnt: macroblock x/y raster walker.
// load latches the frame size and rewinds to (0,0); adv steps one MB in raster order.
module intra16_mb_raster_cnt
    import intra16_mb_scheduler_pkg::*;
#(
    parameter int MBW_W = MBW_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    input  logic [MBW_W-1:0] mb_w,
    input  logic [MBW_W-1:0] mb_h,
    output logic [MBW_W-1:0] x,
    output logic [MBW_W-1:0] y,
    output logic             last_mb
);

    localparam logic [MBW_W-1:0] ONE = MBW_W'(1);

    logic [MBW_W-1:0] w_q, w_d;
    logic [MBW_W-1:0] h_q, h_d;
    logic [MBW_W-1:0] x_q, x_d;
    logic [MBW_W-1:0] y_q, y_d;
    logic             x_end;

    assign x_end   = (x_q == w_q - ONE);
    assign last_mb = x_end && (y_q == h_q - ONE);
    assign x       = x_q;
    assign y       = y_q;

    // Next coordinate: rewind on load, otherwise raster step on adv.
    always_comb begin
        w_d = w_q;
        h_d = h_q;
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            w_d = mb_w;
            h_d = mb_h;
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_q + ONE;
            end else begin
                x_d = x_q + ONE;
            end
        end
    end

    // Coordinate and frame-size registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            h_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else begin
            w_q <= w_d;
            h_q <= h_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/intra16_mb_scheduler.sv
// intra16_mb_scheduler: frame-level sequencer for the 16x16 luma intra mode picker.
// Walks MBs in raster order, launches the picker per MB, parks each result in a
// one-entry valid/ready slot and accumulates the frame score.
// Optional WAIT-state watchdog is built when SCHED_WATCHDOG_EN is defined.
//
// state  | meaning
// IDLE   | no frame; waiting for frame_start
// CLEAR  | one-cycle pick_clear to the picker
// FETCH  | src_req high; waiting for src_valid and a free result slot
// LAUNCH | one-cycle pick_start
// WAIT   | picker running; capture on pick_done
// DRAIN  | last result waiting for downstream acceptance
// DONE   | frame finished; frame_done and busy drop follow
module intra16_mb_scheduler
    import intra16_mb_scheduler_pkg::*;
#(
    parameter int MBW_W   = MBW_W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               abort,
    input  logic [MBW_W-1:0]   mb_w,
    input  logic [MBW_W-1:0]   mb_h,
    input  logic               src_valid,
    output logic               src_req,
    output logic               pick_start,
    output logic               pick_clear,
    output logic [MBW_W-1:0]   pick_x,
    output logic [MBW_W-1:0]   pick_y,
    input  logic               pick_done,
    input  logic [SCORE_W-1:0] pick_score,
    input  logic [31:0]        pick_mode,
    input  logic [NZ_W-1:0]    pick_nz,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [MBW_W-1:0]   res_x,
    output logic [MBW_W-1:0]   res_y,
    output logic [MODE_W-1:0]  res_mode,
    output logic [NZ_W-1:0]    res_nz,
    output logic [SCORE_W-1:0] res_score,
    output logic [SCORE_W-1:0] frame_score,
    output logic               busy,
    output logic               frame_done,
    output logic               err_timeout
);

    sched_state_e       state_q, state_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               res_valid_q, res_valid_d;
    logic               err_timeout_q, err_timeout_d;
    mb_result_t         res_q, res_d;
    logic [MBW_W-1:0]   res_x_q, res_x_d;
    logic [MBW_W-1:0]   res_y_q, res_y_d;
    logic [SCORE_W-1:0] frame_score_q, frame_score_d;

    logic               rc_load;
    logic               rc_adv;
    logic               rc_last;
    logic [MBW_W-1:0]   rc_x;
    logic [MBW_W-1:0]   rc_y;
    logic               xfer;
    logic               wd_expire;
    logic               unused_mode;

    assign unused_mode = ^pick_mode[31:MODE_W];

    intra16_mb_raster_cnt #(
        .MBW_W (MBW_W)
    ) u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (rc_load),
        .adv     (rc_adv),
        .mb_w    (mb_w),
        .mb_h    (mb_h),
        .x       (rc_x),
        .y       (rc_y),
        .last_mb (rc_last)
    );

    assign xfer = res_valid_q && res_ready;

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // WAIT-state cycle counter; rewound while launching so each MB gets a full budget.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_LAUNCH) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_expire = (state_q == ST_WAIT) && !pick_done && (wd_cnt_q == WD_W'(TIMEOUT - 1));
`else
    logic unused_wd;

    assign unused_wd = (TIMEOUT == 0);
    assign wd_expire = 1'b0;
`endif

    // Next-state, slot and score logic; abort/watchdog override everything else.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        res_valid_d   = res_valid_q;
        res_d         = res_q;
        res_x_d       = res_x_q;
        res_y_d       = res_y_q;
        frame_score_d = frame_score_q;
        err_timeout_d = err_timeout_q;
        rc_load       = 1'b0;
        rc_adv        = 1'b0;

        if (xfer) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    rc_load       = 1'b1;
                    frame_score_d = '0;
                    busy_d        = 1'b1;
                    err_timeout_d = 1'b0;
                    if ((mb_w == '0) || (mb_h == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (src_valid && slot_free(res_valid_q, res_ready)) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pick_done) begin
                    res_d.mode    = pick_mode[MODE_W-1:0];
                    res_d.nz      = pick_nz;
                    res_d.score   = pick_score;
                    res_x_d       = rc_x;
                    res_y_d       = rc_y;
                    res_valid_d   = 1'b1;
                    frame_score_d = frame_score_q + pick_score;
                    rc_adv        = 1'b1;
                    state_d       = rc_last ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort || wd_expire) begin
            state_d       = ST_IDLE;
            busy_d        = 1'b0;
            res_valid_d   = 1'b0;
            frame_done_d  = 1'b0;
            frame_score_d = frame_score_q;
            err_timeout_d = err_timeout_q | wd_expire;
            rc_load       = 1'b0;
            rc_adv        = 1'b0;
        end
    end

    // Controller and result-slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            res_q         <= '0;
            res_x_q       <= '0;
            res_y_q       <= '0;
            frame_score_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            res_valid_q   <= res_valid_d;
            err_timeout_q <= err_timeout_d;
            res_q         <= res_d;
            res_x_q       <= res_x_d;
            res_y_q       <= res_y_d;
            frame_score_q <= frame_score_d;
        end
    end

    assign src_req     = (state_q == ST_FETCH);
    assign pick_start  = (state_q == ST_LAUNCH);
    assign pick_clear  = (state_q == ST_CLEAR);
    assign pick_x      = rc_x;
    assign pick_y      = rc_y;
    assign res_valid   = res_valid_q;
    assign res_x       = res_x_q;
    assign res_y       = res_y_q;
    assign res_mode    = res_q.mode;
    assign res_nz      = res_q.nz;
    assign res_score   = res_q.score;
    assign frame_score = frame_score_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_intra16_mb_scheduler.sv
// tb_intra16_mb_scheduler: frame table, hand sequences and randomized frames
// checked against a raster-order reference of expected results.
module tb_intra16_mb_scheduler;

    localparam int MBW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           frame_start, abort, src_valid, pick_done, res_ready;
    logic [MBW-1:0] mb_w, mb_h;
    logic [63:0]    pick_score;
    logic [31:0]    pick_mode, pick_nz;
    logic           src_req, pick_start, pick_clear, res_valid, busy, frame_done, err_timeout;
    logic [MBW-1:0] pick_x, pick_y, res_x, res_y;
    logic [1:0]     res_mode;
    logic [31:0]    res_nz;
    logic [63:0]    res_score, frame_score;

    intra16_mb_scheduler #(.MBW_W(MBW), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
        .mb_w(mb_w), .mb_h(mb_h), .src_valid(src_valid), .src_req(src_req),
        .pick_start(pick_start), .pick_clear(pick_clear), .pick_x(pick_x), .pick_y(pick_y),
        .pick_done(pick_done), .pick_score(pick_score), .pick_mode(pick_mode), .pick_nz(pick_nz),
        .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
        .res_mode(res_mode), .res_nz(res_nz), .res_score(res_score),
        .frame_score(frame_score), .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
    );

    typedef struct {
        int          w;
        int          h;
        int          lat;
        int          ready_pct;
        int          src_pct;
        bit          fixed;
        bit          noise;
        int          exp_mbs;
        int          exp_clears;
        int          exp_done;
        logic [63:0] exp_score;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          m_w, m_h, m_lat, ready_pct, src_pct;
    bit          noise, pk_never, stray_done, pk_pending, exp_valid_next;
    bit          prev_req, prev_sv, fs_req, ab_req;
    logic [63:0] sc [64];
    logic [31:0] md [64];
    logic [31:0] nzv [64];
    logic [63:0] m_sum;
    int          clr_cnt, done_cnt, acc_cnt, start_idx;
    int          first_clr, first_req, done_cyc, fs_cyc, pk_due, pk_idx;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected result record for the idx-th MB of the frame in raster order.
    function automatic logic [117:0] exp_res(input int idx);
        logic [MBW-1:0] ex, ey;
        if (idx >= 64 || m_w <= 0) return '1;
        ex = MBW'(idx % m_w);
        ey = MBW'(idx / m_w);
        return {ex, ey, md[idx][1:0], nzv[idx], sc[idx]};
    endfunction

    // One clock: observe outputs at the falling edge, then drive this cycle's inputs.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (exp_valid_next) begin
            check("done_to_valid", res_valid, 1);
            exp_valid_next = 0;
        end
        if (pick_clear) begin
            clr_cnt++;
            if (first_clr < 0) first_clr = cyc;
        end
        if (src_req && first_req < 0) first_req = cyc;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pick_start) begin
            if (m_w > 0)
                check("start_xy", {pick_x, pick_y}, {MBW'(start_idx % m_w), MBW'(start_idx / m_w)});
            check("start_slot_free", acc_cnt, start_idx);
            check("start_after_src", {prev_req, prev_sv}, 2'b11);
            pk_pending = 1;
            pk_due     = cyc + m_lat;
            pk_idx     = (start_idx < 64) ? start_idx : 63;
            start_idx++;
        end
        prev_req = src_req;

        res_ready = ($urandom_range(99) < ready_pct);
        if (res_valid) begin
            check("res_fields", {res_x, res_y, res_mode, res_nz, res_score}, exp_res(acc_cnt));
            if (res_ready) acc_cnt++;
        end
        if (pk_pending && !pk_never && cyc >= pk_due) begin
            pick_done      = 1'b1;
            pick_score     = sc[pk_idx];
            pick_mode      = md[pk_idx];
            pick_nz        = nzv[pk_idx];
            pk_pending     = 0;
            exp_valid_next = 1;
        end else begin
            pick_done  = stray_done;
            pick_score = {$urandom, $urandom};
            pick_mode  = $urandom;
            pick_nz    = $urandom;
        end
        src_valid   = ($urandom_range(99) < src_pct);
        prev_sv     = src_valid;
        frame_start = fs_req || (noise && busy && ($urandom_range(9) == 0));
        if (noise && busy) begin
            mb_w = MBW'($urandom);
            mb_h = MBW'($urandom);
        end
        fs_req = 0;
        abort  = ab_req;
        ab_req = 0;
    endtask

    task automatic start_frame(input int w, input int h, input int lat, input int rp,
                               input int sp, input bit fixed, input bit nz_noise);
        m_w = w; m_h = h; m_lat = lat; ready_pct = rp; src_pct = sp; noise = nz_noise;
        m_sum = '0;
        for (int k = 0; k < 64; k++) begin
            if (fixed) begin
                sc[k]  = 64'(100 * (k + 1));
                md[k]  = 32'(k);
                nzv[k] = 32'(3 * k);
            end else begin
                sc[k]  = {$urandom, $urandom};
                md[k]  = $urandom;
                nzv[k] = $urandom;
            end
            if (k < w * h) m_sum = m_sum + sc[k];
        end
        clr_cnt = 0; done_cnt = 0; acc_cnt = 0; start_idx = 0;
        first_clr = -1; first_req = -1; done_cyc = -1;
        pk_pending = 0; exp_valid_next = 0;
        mb_w = MBW'(w);
        mb_h = MBW'(h);
        fs_req = 1;
        cycle();
        fs_cyc = cyc;
    endtask

    task automatic finish_frame(input int exp_mbs, input int exp_clears, input int exp_done,
                                input bit fixed, input logic [63:0] fixed_score);
        for (int i = 0; i < 6000 && done_cnt == 0; i++) cycle();
        if (done_cnt == 0) check("frame_done_timeout", 0, 1);
        noise = 0;
        repeat (3) cycle();
        check("mb_count", acc_cnt, exp_mbs);
        check("start_count", start_idx, exp_mbs);
        check("clear_count", clr_cnt, exp_clears);
        check("done_count", done_cnt, exp_done);
        check("frame_score", frame_score, fixed ? fixed_score : m_sum);
        check("busy_after", busy, 0);
        if (exp_mbs == 0) begin
            check("zero_done_lat", done_cyc - fs_cyc, 2);
        end else begin
            check("clear_lat", first_clr - fs_cyc, 1);
            check("req_lat", first_req - first_clr, 1);
        end
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{2, 2, 20, 100, 100, 1'b1, 1'b0, 4, 1, 1, 64'd1000};
        tbl[1] = '{0, 5, 3, 100, 100, 1'b0, 1'b0, 0, 0, 1, 64'd0};
        tbl[2] = '{3, 0, 3, 100, 100, 1'b0, 1'b0, 0, 0, 1, 64'd0};
        tbl[3] = '{1, 1, 1, 100, 100, 1'b0, 1'b0, 1, 1, 1, 64'd0};
        tbl[4] = '{3, 2, 3, 50, 70, 1'b0, 1'b0, 6, 1, 1, 64'd0};
        tbl[5] = '{4, 1, 1, 30, 100, 1'b0, 1'b1, 4, 1, 1, 64'd0};
        tbl[6] = '{1, 3, 2, 80, 40, 1'b0, 1'b1, 3, 1, 1, 64'd0};

        rst_n = 0; frame_start = 0; abort = 0; src_valid = 0; pick_done = 0; res_ready = 0;
        mb_w = '0; mb_h = '0; pick_score = '0; pick_mode = '0; pick_nz = '0;
        m_w = 1; m_h = 1; m_lat = 1; ready_pct = 100; src_pct = 100;
        noise = 0; pk_never = 0; stray_done = 0; fs_req = 0; ab_req = 0;
        prev_req = 0; prev_sv = 0; pk_pending = 0; exp_valid_next = 0;
        clr_cnt = 0; done_cnt = 0; acc_cnt = 0; start_idx = 0;
        first_clr = -1; first_req = -1; done_cyc = -1; fs_cyc = 0; pk_due = 0; pk_idx = 0;

        repeat (3) cycle();
        check("reset_ctrl", {src_req, pick_start, pick_clear, res_valid, busy, frame_done, err_timeout,
                             pick_x, pick_y}, '0);
        check("reset_res", {res_x, res_y, res_mode, res_nz, res_score}, '0);
        check("reset_score", frame_score, '0);
        rst_n = 1;
        repeat (2) cycle();

        // Frame table.
        for (int t = 0; t < 7; t++) begin
            start_frame(tbl[t].w, tbl[t].h, tbl[t].lat, tbl[t].ready_pct, tbl[t].src_pct,
                        tbl[t].fixed, tbl[t].noise);
            finish_frame(tbl[t].exp_mbs, tbl[t].exp_clears, tbl[t].exp_done,
                         tbl[t].fixed, tbl[t].exp_score);
        end

        // Downstream stall: first result must hold and the next MB must not launch.
        start_frame(3, 1, 4, 0, 100, 0, 0);
        for (int i = 0; i < 200 && !res_valid; i++) cycle();
        repeat (30) cycle();
        check("stall_no_launch", start_idx, 1);
        check("stall_none_taken", acc_cnt, 0);
        ready_pct = 100;
        finish_frame(3, 1, 1, 0, '0);

        // Abort while MB (1,0) is in the picker.
        start_frame(2, 2, 20, 100, 100, 0, 0);
        for (int i = 0; i < 500 && start_idx < 2; i++) cycle();
        repeat (5) cycle();
        ab_req = 1;
        cycle();
        pk_pending = 0;
        cycle();
        check("abort_ctrl", {busy, res_valid, src_req, pick_start}, 4'b0000);
        check("abort_score_hold", frame_score, sc[0]);
        stray_done = 1;
        cycle();
        stray_done = 0;
        cycle();
        check("stray_done_ignored", res_valid, 0);
        check("stray_score_hold", frame_score, sc[0]);
        repeat (3) cycle();
        check("abort_no_done", done_cnt, 0);
        start_frame(2, 2, 3, 100, 100, 0, 0);
        finish_frame(4, 1, 1, 0, '0);

        // Abort with the result slot full drops the parked result.
        start_frame(2, 1, 3, 0, 100, 0, 0);
        for (int i = 0; i < 200 && !res_valid; i++) cycle();
        ab_req = 1;
        ready_pct = 0;
        cycle();
        cycle();
        check("abort_slot_clear", {res_valid, busy}, 2'b00);
        check("abort_slot_score", frame_score, sc[0]);
        repeat (3) cycle();
        check("abort_slot_no_done", done_cnt, 0);

        // Abort beats a coincident frame_start.
        mb_w = MBW'(2);
        mb_h = MBW'(2);
        clr_cnt = 0;
        ab_req = 1;
        fs_req = 1;
        cycle();
        cycle();
        cycle();
        check("abort_prio", {busy, pick_clear}, 2'b00);
        check("abort_prio_clears", clr_cnt, 0);

        // Picker that never finishes.
        pk_never = 1;
        start_frame(1, 1, 1, 100, 100, 0, 0);
        repeat (40) cycle();
`ifdef SCHED_WATCHDOG_EN
        check("wd_busy", busy, 0);
        check("wd_err", err_timeout, 1);
        pk_pending = 0;
        pk_never = 0;
        repeat (3) cycle();
        check("wd_err_sticky", err_timeout, 1);
        start_frame(1, 1, 2, 100, 100, 0, 0);
        cycle();
        check("wd_err_cleared", err_timeout, 0);
        finish_frame(1, 1, 1, 0, '0);
`else
        check("nowd_busy", busy, 1);
        check("nowd_err", err_timeout, 0);
        ab_req = 1;
        cycle();
        pk_pending = 0;
        pk_never = 0;
        cycle();
        check("nowd_abort", busy, 0);
`endif

        // Randomized frames with mid-frame frame_start and size noise.
        for (int r = 0; r < 8; r++) begin
            int w, h;
            w = $urandom_range(5, 1);
            h = $urandom_range(5, 1);
            start_frame(w, h, $urandom_range(6, 1), $urandom_range(100, 20),
                        $urandom_range(100, 30), 0, 1);
            finish_frame(w * h, 1, 1, 0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
